mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
// Memory-side responder for the multicycle core's load/store/fetch port. Accepts one request at a
//   time through a Mem_Req/Mem_Ready handshake, with programmable wait states.
// Performs sub-word stores with byte lanes, and sign- or zero-extends loads by funct3.
// Flags misaligned accesses and illegal sizes.
// Backs a synchronous word-organised RAM that holds both instructions and data.
// PARAMETERS
// DEPTH_WORDS  1024  RAM size in 32-bit words; power of two
// WAIT_STATES  1     extra idle cycles inserted before each access; 0..15
// INIT_FILE    ""    hex image loaded with $readmemh when non-empty
// PORTS
// clk         in   1   clock; all state updates on rising edge
// reset       in   1   synchronous, active-high reset
// Mem_Req     in   1   request valid; sampled only in IDLE
// Mem_Write   in   1   1 = store, 0 = load/fetch; latched with request
// Mem_Size    in   3   funct3 of the access (fetch uses 3'b010)
// Adr         in   32  byte address; latched with request
// Write_Data  in   32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
// Read_Data   out  32  extended load result; valid when Mem_Ready=1, then held
// Mem_Ready   out  1   one-cycle pulse: access complete
// Fault       out  1   valid with Mem_Ready: misaligned or illegal size; no write done
// BEHAVIOUR
// Reset: state=IDLE, wait counter=0, Mem_Ready=0, Fault=0, Read_Data=0. RAM contents not cleared.
// FSM states: IDLE -> WAIT -> ACCESS -> RESP -> IDLE.
// IDLE:
//   - With Mem_Req=1, latch Adr, Write_Data, Mem_Size, Mem_Write and load counter=WAIT_STATES.
//   - Next state is WAIT if WAIT_STATES>0, else ACCESS. With Mem_Req=0, stay in IDLE.
// Fault check at latch time; the result is registered:
//   - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
//   - Any other Mem_Size is an illegal size and faults.
//   - Misaligned: halfword with Adr[0]=1, or word with Adr[1:0]!=0.
//   - On a fault, go directly to RESP: Fault=1, Read_Data=0, RAM unchanged.
// WAIT: decrement the counter each cycle; at 1, go to ACCESS. Mem_Req is ignored.
// ACCESS: index = Adr[$clog2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap.
//   - Store: write the lanes selected by Adr[1:0] and size. Data is replicated to its lanes:
//     SB -> {4{b}}, SH -> {2{h}}. Byte enables: SB 0001<<Adr[1:0], SH 0011<<Adr[1:0], SW 1111.
//   - Load: register RAM word.
//   - Next state RESP.
// RESP:
//   - Mem_Ready=1 for exactly one cycle.
//   - Load: Read_Data = selected byte/halfword shifted down by Adr[1:0].
//     Sign-extend for LB/LH; zero-extend for LBU/LHU; LW passes the word through.
//   - Store: Read_Data unchanged.
//   - Next state IDLE. Read_Data and Fault hold until the next RESP.
// Latency: request sampled at edge 0; Mem_Ready high in cycle WAIT_STATES+2 (fault: cycle 1).
// Back-to-back: a new request can be sampled in the cycle after Mem_Ready.
//   - Requester must deassert Mem_Req or present the next request in that cycle.
// Reset mid-operation: reset wins on the same edge and no write is performed.
//   - A pending store in WAIT or ACCESS is aborted; Mem_Ready is not pulsed.
// TESTING
// 1 W=1: SW 0xDEADBEEF @0x40; LW @0x40 -> Mem_Ready in cycle 3 after req, Read_Data=0xDEADBEEF.
// 2 SB 0x80 @0x41; then LB @0x41 -> 0xFFFFFF80, LBU @0x41 -> 0x00000080,
//   LW @0x40 -> 0xDEAD80EF.
// 3 SH 0x1234 @0x42; LHU @0x42 -> 0x00001234; LW @0x40 -> 0x123480EF.
// 4 LW @0x42 -> Fault=1, Mem_Ready in cycle 1, Read_Data=0. SB @0x43 (aligned) -> Fault=0.
//   Mem_Size=3'b011 -> Fault=1.
// 5 SW 0x11111111 @0x80, reset asserted in WAIT; then LW @0x80 returns the prior value (not 0x11111111).
//   Mem_Ready never pulses for the aborted store.
// 6 DEPTH_WORDS=1024: SW 0xCAFE0001 @0x1000 (wraps to word 0), LW @0x0 -> 0xCAFE0001.
//   W=0 back-to-back loads -> Ready every 3rd cycle.

Source files
------------

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the multicycle core's shared instruction/data port.
// One request is in flight at a time. Each accepted request is optionally
// delayed by WAIT_STATES idle cycles, then performs one access on a synchronous
// word-organised RAM, then answers with a one-cycle Mem_Ready pulse. Stores
// write byte lanes selected by size and address. Loads are sign- or
// zero-extended according to funct3. Illegal sizes and misaligned addresses
// are answered with Fault=1, skip the RAM completely, and return zero.
//
// Handshake: Mem_Req is sampled only while the FSM is IDLE. A request is
// accepted on the rising edge where state==IDLE and Mem_Req==1; all request
// fields are latched on that edge and ignored afterwards. Mem_Ready is high
// for exactly one cycle (state RESP). Read_Data and Fault are valid in that
// cycle and hold their values until the next RESP. The cycle after Mem_Ready
// is IDLE again, so the requester either drops Mem_Req or presents the next
// request then.
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous, active-high; aborts any pending access
//   Mem_Req     request valid (sampled in IDLE only)
//   Mem_Write   1 = store, 0 = load/fetch
//   Mem_Size    funct3 of the access (fetch uses 3'b010)
//   Adr         byte address
//   Write_Data  right-aligned store data
//   Read_Data   extended load result, valid with Mem_Ready, then held
//   Mem_Ready   one-cycle completion pulse
//   Fault       misaligned or illegal size, valid with Mem_Ready, then held
//   dbg_state   current FSM state (IDLE=0, WAIT=1, ACCESS=2, RESP=3)
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_Req,
    input  logic        Mem_Write,
    input  logic [2:0]  Mem_Size,
    input  logic [31:0] Adr,
    input  logic [31:0] Write_Data,
    output logic [31:0] Read_Data,
    output logic        Mem_Ready,
    output logic        Fault,
    output logic [1:0]  dbg_state
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [3:0]  wait_cnt, wait_cnt_next;

    // Request fields captured at acceptance
    logic        write_q;
    logic [2:0]  size_q;
    logic [AW+1:0] adr_q;
    logic [31:0] wdata_q;
    logic        fault_q;

    // Registered RAM read word and held response values
    logic [31:0] ram_word_q;
    logic [31:0] read_data_q;
    logic        fault_hold_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        req_fault;
    logic [AW-1:0] idx;
    logic [3:0]  byte_en;
    logic [31:0] store_data;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    // Upper address bits do not select anything: addresses wrap modulo the RAM.
    logic        unused_adr_bits;
    assign unused_adr_bits = ^Adr[31:AW+2];

    // -------------------------------------------------------------------------
    // Fault classification of the incoming request
    // -------------------------------------------------------------------------
    function automatic logic classify_fault(input logic       wr,
                                            input logic [2:0] sz,
                                            input logic [1:0] lo);
        logic illegal;
        logic misaligned;
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (sz)
            3'b000: ;                                   // byte: always aligned
            3'b001: misaligned = lo[0];                 // LH / SH
            3'b010: misaligned = (lo != 2'b00);         // LW / SW / fetch
            3'b100: illegal    = wr;                    // LBU has no store form
            3'b101: begin                               // LHU has no store form
                illegal    = wr;
                misaligned = lo[0];
            end
            default: illegal = 1'b1;
        endcase
        return illegal | misaligned;
    endfunction

    assign accept    = (state == S_IDLE) && Mem_Req;
    assign req_fault = classify_fault(Mem_Write, Mem_Size, Adr[1:0]);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            S_IDLE: begin
                if (Mem_Req) begin
                    wait_cnt_next = WAIT_INIT;
                    if (req_fault)
                        state_next = S_RESP;
                    else if (WAIT_STATES > 0)
                        state_next = S_WAIT;
                    else
                        state_next = S_ACCESS;
                end
            end
            S_WAIT: begin
                wait_cnt_next = wait_cnt - 4'd1;
                // <=1 rather than ==1 so a zero count can never strand the FSM
                if (wait_cnt <= 4'd1)
                    state_next = S_ACCESS;
            end
            S_ACCESS: state_next = S_RESP;
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture and held response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q      <= 1'b0;
            size_q       <= 3'b000;
            adr_q        <= '0;
            wdata_q      <= 32'd0;
            fault_q      <= 1'b0;
            read_data_q  <= 32'd0;
            fault_hold_q <= 1'b0;
        end else begin
            if (accept) begin
                write_q <= Mem_Write;
                size_q  <= Mem_Size;
                adr_q   <= Adr[AW+1:0];
                wdata_q <= Write_Data;
                fault_q <= req_fault;
            end
            if (state == S_RESP) begin
                read_data_q  <= Read_Data;
                fault_hold_q <= Fault;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Store lane steering: data is replicated so every enabled lane sees it
    // -------------------------------------------------------------------------
    assign idx = adr_q[AW+1:2];

    always_comb begin
        byte_en    = 4'b1111;
        store_data = wdata_q;
        case (size_q[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << adr_q[1:0];
                store_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                byte_en    = 4'b0011 << adr_q[1:0];
                store_data = {2{wdata_q[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_data = wdata_q;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // RAM: one access in ACCESS. Reset on the same edge suppresses the write.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && state == S_ACCESS) begin
            ram_word_q <= mem[idx];
            if (write_q) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b])
                        mem[idx][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Load extraction and extension
    // -------------------------------------------------------------------------
    assign shifted = ram_word_q >> {adr_q[1:0], 3'b000};

    always_comb begin
        load_ext = shifted;
        case (size_q)
            3'b000:  load_ext = {{24{shifted[7]}},  shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: live values in RESP, held copies elsewhere
    // -------------------------------------------------------------------------
    always_comb begin
        Mem_Ready = 1'b0;
        Read_Data = read_data_q;
        Fault     = fault_hold_q;
        if (state == S_RESP) begin
            Mem_Ready = 1'b1;
            Fault     = fault_q;
            if (fault_q)
                Read_Data = 32'd0;
            else if (!write_q)
                Read_Data = load_ext;
            else
                Read_Data = read_data_q;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int W1 = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    // DUT with one wait state
    logic        Mem_Req, Mem_Write, Mem_Ready, Fault;
    logic [2:0]  Mem_Size;
    logic [31:0] Adr, Write_Data, Read_Data;
    logic [1:0]  dbg_state;

    // DUT with zero wait states
    logic        Mem_Req0, Mem_Write0, Mem_Ready0, Fault0;
    logic [2:0]  Mem_Size0;
    logic [31:0] Adr0, Write_Data0, Read_Data0;
    logic [1:0]  dbg_state0;

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(W1)) u_dut (
        .clk(clk), .reset(reset), .Mem_Req(Mem_Req), .Mem_Write(Mem_Write),
        .Mem_Size(Mem_Size), .Adr(Adr), .Write_Data(Write_Data),
        .Read_Data(Read_Data), .Mem_Ready(Mem_Ready), .Fault(Fault),
        .dbg_state(dbg_state)
    );

    mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .Mem_Req(Mem_Req0), .Mem_Write(Mem_Write0),
        .Mem_Size(Mem_Size0), .Adr(Adr0), .Write_Data(Write_Data0),
        .Read_Data(Read_Data0), .Mem_Ready(Mem_Ready0), .Fault(Fault0),
        .dbg_state(dbg_state0)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic        flt_q[$];
    int          lat_q[$];
    logic [31:0] last_rd;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // ---------------- drivers ----------------
    // One access on u_dut. Expected data: 0 on fault, unchanged for stores,
    // load_val for loads. Expected latency: 1 on fault, W1+2 otherwise.
    task automatic do_access(input string tag, input logic w, input logic [2:0] sz,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] load_val, input logic flt);
        logic [31:0] e_rd, got_rd;
        logic        e_flt;
        int          e_lat, lat;
        e_rd = flt ? 32'd0 : (w ? last_rd : load_val);
        exp_q.push_back(e_rd);
        flt_q.push_back(flt);
        lat_q.push_back(flt ? 1 : W1 + 2);
        last_rd = e_rd;

        @(negedge clk);
        Mem_Req = 1'b1; Mem_Write = w; Mem_Size = sz; Adr = a; Write_Data = wd;
        @(posedge clk);
        #1 Mem_Req = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (Mem_Ready) lat = k;
        end
        e_rd  = exp_q.pop_front();
        e_flt = flt_q.pop_front();
        e_lat = lat_q.pop_front();
        chk({tag, " latency"}, 32'(lat), 32'(e_lat));
        if (lat != 0) begin
            got_rd = Read_Data;
            chk({tag, " read_data"}, got_rd, e_rd);
            chk({tag, " fault"}, {31'd0, Fault}, {31'd0, e_flt});
            @(negedge clk);
            chk({tag, " ready single pulse"}, {31'd0, Mem_Ready}, 32'd0);
            chk({tag, " read_data held"}, Read_Data, e_rd);
            chk({tag, " fault held"}, {31'd0, Fault}, {31'd0, e_flt});
        end
    endtask

    // Store on u_dut that is killed by reset sampled at the end of cycle rst_cycle.
    task automatic abort_store(input string tag, input logic [31:0] a,
                               input logic [31:0] wd, input int rst_cycle);
        int pulses;
        pulses = 0;
        @(negedge clk);
        Mem_Req = 1'b1; Mem_Write = 1'b1; Mem_Size = 3'b010; Adr = a; Write_Data = wd;
        @(posedge clk);
        #1 Mem_Req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (Mem_Ready) pulses++;
            if (k == rst_cycle) reset = 1'b1;
            if (k == rst_cycle + 2) reset = 1'b0;
        end
        chk({tag, " no ready pulse"}, 32'(pulses), 32'd0);
        chk({tag, " state idle"}, {30'd0, dbg_state}, 32'd0);
        chk({tag, " read_data cleared"}, Read_Data, 32'd0);
        chk({tag, " fault cleared"}, {31'd0, Fault}, 32'd0);
        last_rd = 32'd0;
    endtask

    // Word store on u_dut0 (no wait states -> ready in cycle 2).
    task automatic store0(input logic [31:0] a, input logic [31:0] wd);
        int lat;
        lat = 0;
        @(negedge clk);
        Mem_Req0 = 1'b1; Mem_Write0 = 1'b1; Mem_Size0 = 3'b010; Adr0 = a; Write_Data0 = wd;
        @(posedge clk);
        #1 Mem_Req0 = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (Mem_Ready0) lat = k;
        end
        chk("w0 store latency", 32'(lat), 32'd2);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n_seen, prev;
        reset = 1'b1;
        Mem_Req = 1'b0; Mem_Write = 1'b0; Mem_Size = 3'b010; Adr = 32'd0; Write_Data = 32'd0;
        Mem_Req0 = 1'b0; Mem_Write0 = 1'b0; Mem_Size0 = 3'b010; Adr0 = 32'd0; Write_Data0 = 32'd0;
        last_rd = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset state", {30'd0, dbg_state}, 32'd0);
        chk("reset ready", {31'd0, Mem_Ready}, 32'd0);
        chk("reset fault", {31'd0, Fault}, 32'd0);
        chk("reset read_data", Read_Data, 32'd0);
        reset = 1'b0;

        // word store / load
        do_access("sw 40",  1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0);
        do_access("lw 40",  1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);

        // byte store, signed/unsigned byte loads
        do_access("sb 41",  1'b1, 3'b000, 32'h41, 32'h12345680, 32'h0, 1'b0);
        do_access("lb 41",  1'b0, 3'b000, 32'h41, 32'h0, 32'hFFFFFF80, 1'b0);
        do_access("lbu 41", 1'b0, 3'b100, 32'h41, 32'h0, 32'h00000080, 1'b0);
        do_access("lw 40b", 1'b0, 3'b010, 32'h40, 32'h0, 32'hDEAD80EF, 1'b0);

        // halfword store and loads
        do_access("sh 42",  1'b1, 3'b001, 32'h42, 32'hABCD1234, 32'h0, 1'b0);
        do_access("lhu 42", 1'b0, 3'b101, 32'h42, 32'h0, 32'h00001234, 1'b0);
        do_access("lw 40c", 1'b0, 3'b010, 32'h40, 32'h0, 32'h123480EF, 1'b0);
        do_access("lh 40",  1'b0, 3'b001, 32'h40, 32'h0, 32'hFFFF80EF, 1'b0);
        do_access("lh 42",  1'b0, 3'b001, 32'h42, 32'h0, 32'h00001234, 1'b0);
        do_access("lb 40",  1'b0, 3'b000, 32'h40, 32'h0, 32'hFFFFFFEF, 1'b0);
        do_access("lbu 43", 1'b0, 3'b100, 32'h43, 32'h0, 32'h00000012, 1'b0);

        // faults: misaligned and illegal sizes, none of which may write
        do_access("lw 42 misaligned", 1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 1'b1);
        do_access("sb 43 aligned",    1'b1, 3'b000, 32'h43, 32'h00000077, 32'h0, 1'b0);
        do_access("size 011 illegal", 1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1);
        do_access("sh 41 misaligned", 1'b1, 3'b001, 32'h41, 32'h0000FFFF, 32'h0, 1'b1);
        do_access("store size 100",   1'b1, 3'b100, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_access("lw 40 after faults", 1'b0, 3'b010, 32'h40, 32'h0, 32'h773480EF, 1'b0);

        // reset aborts a store in WAIT and in ACCESS
        do_access("sw 80",  1'b1, 3'b010, 32'h80, 32'hA5A5A5A5, 32'h0, 1'b0);
        do_access("lw 80",  1'b0, 3'b010, 32'h80, 32'h0, 32'hA5A5A5A5, 1'b0);
        abort_store("abort in wait",   32'h80, 32'h11111111, 1);
        abort_store("abort in access", 32'h80, 32'h22222222, 2);
        do_access("lw 80 after abort", 1'b0, 3'b010, 32'h80, 32'h0, 32'hA5A5A5A5, 1'b0);

        // address wrap at 1024 words
        do_access("sw 1000 wrap", 1'b1, 3'b010, 32'h1000, 32'hCAFE0001, 32'h0, 1'b0);
        do_access("lw 0",         1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFE0001, 1'b0);
        do_access("lw ffff1000",  1'b0, 3'b010, 32'hFFFF1000, 32'h0, 32'hCAFE0001, 1'b0);

        // zero wait states: back-to-back loads complete every third cycle
        store0(32'h0, 32'h01010101);
        store0(32'h4, 32'h02020202);
        store0(32'h8, 32'h03030303);
        exp_q.push_back(32'h01010101);
        exp_q.push_back(32'h02020202);
        exp_q.push_back(32'h03030303);
        @(negedge clk);
        Mem_Req0 = 1'b1; Mem_Write0 = 1'b0; Mem_Size0 = 3'b010; Adr0 = 32'h0;
        n_seen = 0;
        prev   = 0;
        for (int k = 1; k <= 30 && n_seen < 3; k++) begin
            @(negedge clk);
            if (Mem_Ready0) begin
                chk("b2b data", Read_Data0, exp_q.pop_front());
                if (n_seen == 0) chk("b2b first latency", 32'(k), 32'd2);
                else             chk("b2b spacing", 32'(k - prev), 32'd3);
                prev = k;
                n_seen++;
                if (n_seen < 3) Adr0 = 32'(n_seen * 4);
                else            Mem_Req0 = 1'b0;
            end
        end
        chk("b2b count", 32'(n_seen), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
